// File: rtl/sram_oq_write_ctrl.sv
// sram_oq_write_ctrl: takes the arbiter's word stream, places each word in the
// circular SRAM region of its output queue, buffers it in a small skid FIFO and
// issues SRAM writes. Keeps per-queue occupancy, drops whole packets that do not
// fit and announces every fully written packet to the read-side scheduler.
module sram_oq_write_ctrl #(
  parameter int NUM_QUEUES  = 5,
  parameter int DATA_WIDTH  = 202,
  parameter int QID_WIDTH   = 3,
  parameter int QDEPTH_BITS = 16,
  parameter int SKID_DEPTH  = 4
) (
  input  logic                             memclk,
  input  logic                             reset,
  input  logic                             din_valid,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic [QID_WIDTH-1:0]             queue_id,
  output logic                             sram_wr_en,
  output logic [QID_WIDTH+QDEPTH_BITS-1:0] sram_wr_addr,
  output logic [DATA_WIDTH-1:0]            sram_wr_data,
  input  logic                             sram_wr_ready,
  input  logic                             rd_free_valid,
  input  logic [QID_WIDTH-1:0]             rd_free_qid,
  input  logic [QDEPTH_BITS:0]             rd_free_words,
  output logic                             pkt_commit,
  output logic [QID_WIDTH-1:0]             pkt_commit_qid,
  output logic [QDEPTH_BITS-1:0]           pkt_commit_addr,
  output logic [QDEPTH_BITS:0]             pkt_commit_len,
  output logic [NUM_QUEUES-1:0]            queue_full,
  output logic                             drop_pulse,
  output logic [31:0]                      drop_count
);

  // Occupancy and packet length need one extra bit: a region can be exactly full.
  localparam int OW  = QDEPTH_BITS + 1;
  localparam int SPW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [OW-1:0]  QSIZE     = {1'b1, {QDEPTH_BITS{1'b0}}};
  localparam logic [SPW:0]   SKID_FULL = (SPW+1)'(SKID_DEPTH);

  typedef struct packed {
    logic [QID_WIDTH-1:0]   qid;
    logic [QDEPTH_BITS-1:0] off;
    logic [QDEPTH_BITS-1:0] start;
    logic [OW-1:0]          len;
    logic [DATA_WIDTH-1:0]  data;
  } entry_t;

  // Per-queue state, gathered into flat vectors for the input-side selection.
  logic [NUM_QUEUES-1:0][QDEPTH_BITS-1:0] wr_ptr_all;
  logic [NUM_QUEUES-1:0][QDEPTH_BITS-1:0] start_ptr_all;
  logic [NUM_QUEUES-1:0][OW-1:0]          occ_all;
  logic [NUM_QUEUES-1:0][OW-1:0]          cur_len_all;

  logic                   sel_hit;
  logic [QDEPTH_BITS-1:0] sel_wr_ptr;
  logic [QDEPTH_BITS-1:0] sel_start;
  logic [OW-1:0]          sel_occ;
  logic [OW-1:0]          sel_len;

  logic   eop_in;
  logic   fifo_full;
  logic   fifo_empty;
  logic   can_accept;
  logic   accept;
  logic   fail;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head;

  logic dropping_reg;
  logic dropping_next;

  entry_t            fifo_mem [SKID_DEPTH];
  logic [SPW-1:0]    wr_idx_reg;
  logic [SPW-1:0]    rd_idx_reg;
  logic [SPW:0]      count_reg;

  logic                   commit_reg;
  logic [QID_WIDTH-1:0]   commit_qid_reg;
  logic [QDEPTH_BITS-1:0] commit_addr_reg;
  logic [OW-1:0]          commit_len_reg;
  logic                   drop_pulse_reg;
  logic [31:0]            drop_count_reg;

  // Pick the state of the queue addressed by queue_id; no hit means an invalid id.
  always_comb begin
    sel_hit    = 1'b0;
    sel_wr_ptr = '0;
    sel_start  = '0;
    sel_occ    = '0;
    sel_len    = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (queue_id == QID_WIDTH'(i)) begin
        sel_hit    = 1'b1;
        sel_wr_ptr = wr_ptr_all[i];
        sel_start  = start_ptr_all[i];
        sel_occ    = occ_all[i];
        sel_len    = cur_len_all[i];
      end
    end
  end

  assign eop_in     = din[DATA_WIDTH-1];
  assign fifo_full  = (count_reg == SKID_FULL);
  assign fifo_empty = (count_reg == '0);
  assign can_accept = sel_hit && (sel_occ != QSIZE) && !fifo_full;
  assign accept     = din_valid && !dropping_reg && can_accept;
  // A word arriving while already dropping is discarded silently, not re-counted.
  assign fail       = din_valid && !dropping_reg && !can_accept;
  assign push       = accept;
  assign pop        = sram_wr_en && sram_wr_ready;

  // Dropping starts on a failed non-EOP word and ends with the packet's EOP.
  always_comb begin
    dropping_next = dropping_reg;
    if (din_valid) begin
      if (dropping_reg) begin
        if (eop_in) dropping_next = 1'b0;
      end else if (!can_accept && !eop_in) begin
        dropping_next = 1'b1;
      end
    end
  end

  // Build the FIFO entry for the accepted word from the selected queue's state.
  always_comb begin
    push_entry       = '0;
    push_entry.qid   = queue_id;
    push_entry.off   = sel_wr_ptr;
    push_entry.start = sel_start;
    push_entry.len   = sel_len + OW'(1);
    push_entry.data  = din;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
      logic                   hit_q;
      logic                   acc_q;
      logic                   rb_q;
      logic                   free_q;
      logic [OW:0]            occ_up;
      logic [OW:0]            occ_down;
      logic [OW:0]            occ_diff;
      logic [QDEPTH_BITS-1:0] wr_ptr_reg;
      logic [QDEPTH_BITS-1:0] wr_ptr_next;
      logic [QDEPTH_BITS-1:0] start_ptr_reg;
      logic [QDEPTH_BITS-1:0] start_ptr_next;
      logic [OW-1:0]          occ_reg;
      logic [OW-1:0]          occ_next;
      logic [OW-1:0]          cur_len_reg;
      logic [OW-1:0]          cur_len_next;

      assign hit_q  = (queue_id == QID_WIDTH'(gi));
      assign acc_q  = accept && hit_q;
      assign rb_q   = fail && hit_q;
      assign free_q = rd_free_valid && (rd_free_qid == QID_WIDTH'(gi));

      // Rollback and free are summed before clamping so one cycle never wraps below zero.
      assign occ_up   = {1'b0, occ_reg} + {{OW{1'b0}}, acc_q};
      assign occ_down = (rb_q   ? {1'b0, cur_len_reg}   : '0) +
                        (free_q ? {1'b0, rd_free_words} : '0);
      assign occ_diff = occ_up - occ_down;

      // Pointer, length and occupancy updates for this queue.
      always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        start_ptr_next = start_ptr_reg;
        cur_len_next   = cur_len_reg;
        if (rb_q) begin
          wr_ptr_next  = start_ptr_reg;
          cur_len_next = '0;
        end else if (acc_q) begin
          wr_ptr_next = wr_ptr_reg + QDEPTH_BITS'(1);
          if (eop_in) begin
            cur_len_next   = '0;
            start_ptr_next = wr_ptr_reg + QDEPTH_BITS'(1);
          end else begin
            cur_len_next = cur_len_reg + OW'(1);
          end
        end
        occ_next = (occ_up > occ_down) ? occ_diff[OW-1:0] : '0;
      end

      // Per-queue state registers.
      always_ff @(posedge memclk) begin
        if (reset) begin
          wr_ptr_reg    <= '0;
          start_ptr_reg <= '0;
          occ_reg       <= '0;
          cur_len_reg   <= '0;
        end else begin
          wr_ptr_reg    <= wr_ptr_next;
          start_ptr_reg <= start_ptr_next;
          occ_reg       <= occ_next;
          cur_len_reg   <= cur_len_next;
        end
      end

      assign wr_ptr_all[gi]    = wr_ptr_reg;
      assign start_ptr_all[gi] = start_ptr_reg;
      assign occ_all[gi]       = occ_reg;
      assign cur_len_all[gi]   = cur_len_reg;
      assign queue_full[gi]    = (occ_reg == QSIZE);
    end
  endgenerate

  // Skid FIFO storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge memclk) begin
    if (push) fifo_mem[wr_idx_reg] <= push_entry;
  end

  // Skid FIFO pointers and fill count.
  always_ff @(posedge memclk) begin
    if (reset) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_idx_reg <= wr_idx_reg + SPW'(1);
      if (pop)  rd_idx_reg <= rd_idx_reg + SPW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (SPW+1)'(1);
        2'b01:   count_reg <= count_reg - (SPW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head = fifo_mem[rd_idx_reg];

  // Head of the FIFO drives the write port; zero when idle so nothing stale leaks out.
  assign sram_wr_en   = !fifo_empty;
  assign sram_wr_addr = fifo_empty ? '0 : {head.qid, head.off};
  assign sram_wr_data = fifo_empty ? '0 : head.data;

  // Input-side drop state.
  always_ff @(posedge memclk) begin
    if (reset) dropping_reg <= 1'b0;
    else       dropping_reg <= dropping_next;
  end

  // Commit announcement follows the SRAM's acceptance of the EOP word.
  always_ff @(posedge memclk) begin
    if (reset) begin
      commit_reg      <= 1'b0;
      commit_qid_reg  <= '0;
      commit_addr_reg <= '0;
      commit_len_reg  <= '0;
    end else begin
      commit_reg <= pop && head.data[DATA_WIDTH-1];
      if (pop && head.data[DATA_WIDTH-1]) begin
        commit_qid_reg  <= head.qid;
        commit_addr_reg <= head.start;
        commit_len_reg  <= head.len;
      end
    end
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge memclk) begin
    if (reset) begin
      drop_pulse_reg <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      drop_pulse_reg <= fail;
      if (fail && (drop_count_reg != '1)) drop_count_reg <= drop_count_reg + 32'd1;
    end
  end

  assign pkt_commit      = commit_reg;
  assign pkt_commit_qid  = commit_qid_reg;
  assign pkt_commit_addr = commit_addr_reg;
  assign pkt_commit_len  = commit_len_reg;
  assign drop_pulse      = drop_pulse_reg;
  assign drop_count      = drop_count_reg;

endmodule
